// File: rtl/mul8_signed_if.sv
// mul8_signed_if: operand/product bundle for the signed 8x8 multiplier
interface mul8_signed_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [15:0] o;
  modport master (output a, output b, input o);
  modport slave (input a, input b, output o);
endinterface

// File: rtl/mul8_signed.sv
// mul8_signed: exact signed 8x8 multiplier, Baugh-Wooley array, carry-save reduction, registered product
module mul8_signed (
  input logic clk,
  input logic rst_n,
  mul8_signed_if.slave bus
);
  logic [15:0] pp [9];
  logic [15:0] s [9];
  logic [15:0] c [9];
  logic [15:0] sum;
  for (genvar i = 0; i < 8; i++) begin : g_pp
    logic [7:0] row;
    // sign-bit-by-magnitude terms are inverted; the sign-by-sign term stays true
    assign row = (i == 7) ? {bus.a[7] & bus.b[7], ~(bus.a[6:0] & {7{bus.b[7]}})}
                          : {~(bus.a[7] & bus.b[i]), bus.a[6:0] & {7{bus.b[i]}}};
    assign pp[i] = 16'(row) << i;
  end
  assign pp[8] = 16'h8100;
  assign s[0] = pp[0];
  assign c[0] = '0;
  for (genvar k = 1; k < 9; k++) begin : g_csa
    assign s[k] = s[k-1] ^ c[k-1] ^ pp[k];
    assign c[k] = {(s[k-1][14:0] & c[k-1][14:0]) | (s[k-1][14:0] & pp[k][14:0]) | (c[k-1][14:0] & pp[k][14:0]), 1'b0};
  end
  assign sum = s[8] + c[8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.o <= '0;
    else bus.o <= sum;
endmodule

// File: tb/tb_mul8_signed.sv
// tb_mul8_signed: directed and exhaustive checks of the registered signed multiplier
module tb_mul8_signed;
  logic clk = 1'b0;
  logic rst_n;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mul8_signed_if bus ();
  mul8_signed dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask
  function automatic logic [15:0] mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction
  task automatic apply(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string tag);
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    chk(tag, bus.o, exp);
  endtask
  initial begin
    logic [7:0] x, y;
    rst_n = 1'b0;
    bus.a = 8'd0;
    bus.b = 8'd0;
    #1;
    chk("reset_t0", bus.o, 16'h0000);
    bus.a = 8'h7f;
    bus.b = 8'h7f;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", bus.o, 16'h0000);
    rst_n = 1'b1;
    apply(8'h80, 8'h80, 16'h4000, "m128xm128");
    apply(8'h80, 8'h7f, 16'hc080, "m128x127");
    apply(8'h7f, 8'h7f, 16'h3f01, "127x127");
    apply(8'hff, 8'hff, 16'h0001, "m1xm1");
    apply(8'hff, 8'h01, 16'hffff, "m1x1");
    apply(8'h00, 8'h80, 16'h0000, "0xm128");
    for (int i = 0; i < 4; i++) begin
      apply(8'd5, 8'hfd, 16'hfff1, "b2b_5xm3");
      apply(8'hf9, 8'hf7, 16'h003f, "b2b_m7xm9");
    end
    apply(8'd100, 8'hce, 16'hec78, "pre_reset");
    #2 rst_n = 1'b0;
    #1 chk("async_reset", bus.o, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_low", bus.o, 16'h0000);
    end
    rst_n = 1'b1;
    apply(8'd100, 8'hce, 16'hec78, "release");
    for (int ia = 0; ia < 256; ia++)
      for (int ib = 0; ib < 256; ib++) begin
        x = 8'(ia);
        y = 8'(ib);
        apply(x, y, mul(x, y), "sweep");
      end
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      apply(x, y, mul(x, y), "sym_ab");
      apply(y, x, mul(x, y), "sym_ba");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul8_signed.md
# mul8_signed

Exact signed 8×8-bit multiplier with a registered 16-bit product. It is the reference (exact) arithmetic core of the multiplier family: approximate variants and the bias-compensation logic are characterised against its output. The design is a single-cycle datapath: a Baugh-Wooley partial-product array, carry-save reduction and a final carry-propagate adder, followed by one output register.

## Interface
- No parameters; operand width is fixed at 8 bits and product width at 16 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  8  multiplicand, two's complement, range -128..127.
- B  input  8  multiplier, two's complement, range -128..127.
- O  output  16  product A×B, two's complement, registered.

## Operation
- Product is exact: O = A × B as signed integers, with no truncation, rounding or approximation.
  - Full range is -16256 (−128×127) to +16384 (−128×−128).
  - 16 bits always suffice, so no overflow or saturation logic.
- Partial products use Baugh-Wooley signed form.
  - pp[i][j] = A[j]&B[i] for i,j < 7, plus pp[7][7].
  - Terms with exactly one sign bit (A[7]&B[j], A[i]&B[7]) are inverted.
  - Constant correction: add 1 at bit 8 and 1 at bit 15.
- Reduction: columns 0..15 are reduced to two rows using full and half adders (Dadda or Wallace; the choice is free).
  - A 16-bit carry-propagate adder then produces the sum.
  - Carry out of bit 15 is discarded.
- The sum is captured into the O register on every rising clk edge. There is no enable and no valid handshake; inputs are sampled every cycle.
- Signedness is required end to end. Treating operands as unsigned is a defect; the checks in the test plan detect it (e.g. −1×−1 must be 1, not 65025 truncated).
- No internal state other than the O register.

## Timing
- Latency is 1 cycle: A and B, stable before rising edge n, appear on O after edge n.
  - O holds the value until edge n+1.
- Throughput is one product per cycle. A new operand pair may be applied every cycle.
- Reset:
  - rst_n low asynchronously forces O = 16'h0000 immediately, independent of clk.
  - O stays 0 while rst_n is low.
- Reset release: the first rising clk edge with rst_n high loads A×B of the inputs present at that edge.
- Reset asserted mid-stream: the in-flight product is lost and O reads 0. There is no recovery obligation; the next post-release edge yields a fresh product.
- The combinational path A/B → O register D input must close at the target clock in a single cycle. No multicycle paths.

## Test plan
- Corner operands, one pair per cycle, each checked one cycle later:
  - −128×−128 → 16384 (0x4000).
  - −128×127 → −16256 (0xC080).
  - 127×127 → 16129 (0x3F01).
  - −1×−1 → 1.
  - −1×1 → −1 (0xFFFF).
  - 0×−128 → 0.
- Exhaustive sweep:
  - Stimulus: all 65536 (A,B) pairs, A outer loop and B inner loop over bit patterns 0x00..0xFF, one pair per cycle.
  - Check: each O equals the signed product of the pair applied the previous cycle. Dump the decimal values for the error-statistics flow.
- Reset behaviour:
  - Apply A=100, B=−50, clock, then assert rst_n asynchronously between edges. O must go to 0 before the next edge.
  - Hold rst_n low for 3 edges: O must stay 0.
  - Release rst_n: the next edge gives O = −5000 (0xEC78).
- Back-to-back pipeline check:
  - Stimulus: alternate (A,B) = (5,−3) and (−7,−9) every cycle.
  - Required: O alternates −15 and 63 with exactly 1-cycle lag, with no bubbles.
- Symmetry: for a random set of ≥1000 pairs, O(A,B) equals O(B,A), and both match a behavioural signed multiply.
